// File: rtl/parity_serializer.sv
// Parallel-to-serial transmitter: shifts out a DATA_W-bit word, optionally followed
// by an even/odd parity bit, with a valid/ready load handshake for gapless frames.
module parity_serializer #(
  parameter int DATA_W    = 7,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = $clog2(DATA_W + 2)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_ParityMode,
  input  logic              i_Load,
  output logic              o_LoadReady,
  output logic              o_serialOutput,
  output logic              o_serialValid,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [CNT_W-1:0]  o_BitCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PAR_IDX   = CNT_W'(DATA_W);

  // Mode 2 (odd) inverts the data XOR; modes 0/3 never send the bit.
  function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [1:0] mode);
    parity_of = (^d) ^ (mode == 2'd2);
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] d);
    if (MSB_FIRST != 0) head_bit = d[DATA_W-1];
    else                head_bit = d[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
    if (MSB_FIRST != 0) advance = d << 1'b1;
    else                advance = d >> 1'b1;
  endfunction

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_par_en;
  logic                r_ser;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;

  logic w_par_en_new;
  logic w_last;
  logic w_load_ready;
  logic w_accept;

  assign w_par_en_new = (i_ParityMode == 2'd1) || (i_ParityMode == 2'd2);
  assign w_last       = (r_state == S_PAR) ||
                        ((r_state == S_DATA) && (r_cnt == LAST_DATA) && !r_par_en);
  assign w_load_ready = !i_Reset && ((r_state == S_IDLE) || w_last);
  assign w_accept     = i_Load && w_load_ready;

  // Frame sequencer: shift register, parity and all registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state  <= S_IDLE;
      r_shift  <= {DATA_W{1'b0}};
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      r_ser    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= CNT_ZERO;
    end else if (w_accept) begin
      r_state  <= S_DATA;
      r_shift  <= advance(i_data);
      r_par    <= parity_of(i_data, i_ParityMode);
      r_par_en <= w_par_en_new;
      r_ser    <= head_bit(i_data);
      r_valid  <= 1'b1;
      r_busy   <= 1'b1;
      r_done   <= (DATA_W == 1) ? !w_par_en_new : 1'b0;
      r_cnt    <= CNT_ZERO;
    end else begin
      case (r_state)
        S_DATA: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_ser   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == LAST_DATA) begin
            r_state <= S_PAR;
            r_ser   <= r_par;
            r_done  <= 1'b1;
            r_cnt   <= PAR_IDX;
          end else begin
            r_ser   <= head_bit(r_shift);
            r_shift <= advance(r_shift);
            r_done  <= ((r_cnt + CNT_ONE) == LAST_DATA) && !r_par_en;
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        S_PAR: begin
          r_state <= S_IDLE;
          r_ser   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= CNT_ZERO;
        end
        S_IDLE: begin
          r_ser   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= CNT_ZERO;
        end
        default: begin
          r_state <= S_IDLE;
          r_ser   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign o_LoadReady    = w_load_ready;
  assign o_serialOutput = r_ser;
  assign o_serialValid  = r_valid;
  assign o_Busy         = r_busy;
  assign o_Done         = r_done;
  assign o_BitCount     = r_cnt;

endmodule

// File: tb/tb_parity_serializer.sv
// Scoreboard bench for parity_serializer: three builds (7/LSB, 7/MSB, 8/LSB) driven
// with directed frames; a forked monitor pops expected bits whenever serialValid=1.
module tb_parity_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] a_data, b_data;
  logic [7:0] c_data;
  logic [1:0] a_mode, b_mode, c_mode;
  logic       a_load, b_load, c_load;
  logic       a_ready, b_ready, c_ready;
  logic       a_ser, b_ser, c_ser;
  logic       a_valid, b_valid, c_valid;
  logic       a_busy, b_busy, c_busy;
  logic       a_done, b_done, c_done;
  logic [3:0] a_cnt, b_cnt, c_cnt;

  parity_serializer #(.DATA_W(7), .MSB_FIRST(0)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_data(a_data), .i_ParityMode(a_mode), .i_Load(a_load),
    .o_LoadReady(a_ready), .o_serialOutput(a_ser), .o_serialValid(a_valid),
    .o_Busy(a_busy), .o_Done(a_done), .o_BitCount(a_cnt));

  parity_serializer #(.DATA_W(7), .MSB_FIRST(1)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_data(b_data), .i_ParityMode(b_mode), .i_Load(b_load),
    .o_LoadReady(b_ready), .o_serialOutput(b_ser), .o_serialValid(b_valid),
    .o_Busy(b_busy), .o_Done(b_done), .o_BitCount(b_cnt));

  parity_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_data(c_data), .i_ParityMode(c_mode), .i_Load(c_load),
    .o_LoadReady(c_ready), .o_serialOutput(c_ser), .o_serialValid(c_valid),
    .o_Busy(c_busy), .o_Done(c_done), .o_BitCount(c_cnt));

  typedef struct {
    logic ser;
    int   cnt;
    logic done;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the first n bits of a frame of 'total' bits; v holds the frame, first bit leftmost.
  task automatic push(input int which, input logic [31:0] v, input int n, input int total);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ser  = v[total-1-i];
      e.cnt  = i;
      e.done = (i == total - 1);
      case (which)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  task automatic cmp(input string name, input exp_t e, input logic ser, input int cnt,
                     input logic done);
    chk({name, "_bit"},  int'(ser),  int'(e.ser));
    chk({name, "_cnt"},  cnt,        e.cnt);
    chk({name, "_done"}, int'(done), int'(e.done));
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_valid) begin
        chk("A_expected_bit", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin e = qa.pop_front(); cmp("A", e, a_ser, int'(a_cnt), a_done); end
      end else chk("A_done_idle", int'(a_done), 0);
      if (b_valid) begin
        chk("B_expected_bit", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin e = qb.pop_front(); cmp("B", e, b_ser, int'(b_cnt), b_done); end
      end else chk("B_done_idle", int'(b_done), 0);
      if (c_valid) begin
        chk("C_expected_bit", int'(qc.size() > 0), 1);
        if (qc.size() > 0) begin e = qc.pop_front(); cmp("C", e, c_ser, int'(c_cnt), c_done); end
      end else chk("C_done_idle", int'(c_done), 0);
    end
  endtask

  task automatic wait_idle(input int which);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = (qa.size() == 0) && !a_busy;
        1:       ok = (qb.size() == 0) && !b_busy;
        default: ok = (qc.size() == 0) && !c_busy;
      endcase
    end
    chk("frame_complete", int'(ok), 1);
    case (which)
      0:       begin chk("A_idle_valid", int'(a_valid), 0); chk("A_idle_cnt", int'(a_cnt), 0); end
      1:       begin chk("B_idle_valid", int'(b_valid), 0); chk("B_idle_cnt", int'(b_cnt), 0); end
      default: begin chk("C_idle_valid", int'(c_valid), 0); chk("C_idle_cnt", int'(c_cnt), 0); end
    endcase
  endtask

  task automatic wait_a_cnt(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = a_valid && (int'(a_cnt) == target);
    end
    chk("A_reach_cnt", int'(found), 1);
  endtask

  task automatic pulse_a(input logic [6:0] d, input logic [1:0] m);
    @(negedge clk);
    a_data = d; a_mode = m; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0; a_data = 7'h00; a_mode = 2'd0;
    chk("A_busy_bit0", int'(a_busy), 1);
  endtask

  int acc;

  initial begin
    rst = 1'b1;
    a_data = 7'h59; b_data = 7'h00; c_data = 8'h00;
    a_mode = 2'd1;  b_mode = 2'd0;  c_mode = 2'd0;
    a_load = 1'b1;  b_load = 1'b0;  c_load = 1'b0;
    fork monitor(); join_none

    // Reset state, with a Load held that must be ignored.
    repeat (3) @(negedge clk);
    chk("rst_ser",   int'(a_ser),   0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_busy",  int'(a_busy),  0);
    chk("rst_cnt",   int'(a_cnt),   0);
    chk("rst_ready", int'(a_ready), 0);
    chk("rst_ready_c", int'(c_ready), 0);
    a_load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", int'(a_ready), 1);
    chk("post_rst_ready_b", int'(b_ready), 1);

    // 7'h59 even, LSB first: 1,0,0,1,1,0,1 + parity 0.
    push(0, 32'b10011010, 8, 8);
    pulse_a(7'h59, 2'd1);
    wait_idle(0);

    // 7'h59 odd, MSB first: 1,0,1,1,0,0,1 + parity 1.
    push(1, 32'b10110011, 8, 8);
    @(negedge clk);
    b_data = 7'h59; b_mode = 2'd2; b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0; b_mode = 2'd0;
    wait_idle(1);

    // 8'hA5 even, LSB first: 1,0,1,0,0,1,0,1 + parity 0.
    push(2, 32'b101001010, 9, 9);
    @(negedge clk);
    c_data = 8'hA5; c_mode = 2'd1; c_load = 1'b1;
    @(negedge clk);
    c_load = 1'b0; c_data = 8'h00;
    wait_idle(2);

    // No parity, Load held high: three back-to-back frames of seven ones.
    push(0, 32'b1111111, 7, 7);
    push(0, 32'b1111111, 7, 7);
    push(0, 32'b1111111, 7, 7);
    @(negedge clk);
    a_data = 7'h7F; a_mode = 2'd0; a_load = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (a_ready) acc++;
      if (acc == 3) break;
      @(negedge clk);
      chk("A_hold_valid", int'(a_valid), 1);
      chk("A_hold_ready", int'(a_ready), int'(a_cnt == 4'd6));
    end
    chk("A_hold_accepts", acc, 3);
    @(negedge clk);
    a_load = 1'b0;
    wait_idle(0);

    // Load at BitCount=3 must be ignored.
    push(0, 32'b10011010, 8, 8);
    pulse_a(7'h59, 2'd1);
    wait_a_cnt(3);
    chk("A_ready_midframe", int'(a_ready), 0);
    a_data = 7'h00; a_mode = 2'd1; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    wait_idle(0);

    // Reset at BitCount=4 aborts the frame with no Done.
    push(0, 32'b10011010, 5, 8);
    pulse_a(7'h59, 2'd1);
    wait_a_cnt(4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", int'(a_valid), 0);
    chk("abort_ser",   int'(a_ser),   0);
    chk("abort_busy",  int'(a_busy),  0);
    chk("abort_done",  int'(a_done),  0);
    chk("abort_cnt",   int'(a_cnt),   0);
    chk("abort_ready", int'(a_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_release_ready", int'(a_ready), 1);
    chk("abort_queue_drained", int'(qa.size()), 0);
    push(0, 32'b10011010, 8, 8);
    pulse_a(7'h59, 2'd1);
    wait_idle(0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_serializer.md
Name: parity_serializer

Overview:
Parameterised parallel-to-serial transmitter that frames a DATA_W-bit word as a serial bit stream with an optional appended parity bit. Parity mode is selectable per frame. Bit order is set at build time. A valid/ready load handshake allows back-to-back frames with no idle gap. The block sits between a parallel data source and a single-wire serial link, and is the general form of the fixed 7-bit even-parity shifter.

Parameters:
DATA_W, 7, number of data bits per frame (legal range 1..32)
MSB_FIRST, 0, 0 = data LSB transmitted first, 1 = data MSB transmitted first
CNT_W, $clog2(DATA_W+2), width of BitCount; must hold values 0..DATA_W

Ports:
Clock  input  1  rising-edge clock, the only clock
Reset  input  1  synchronous, active-high reset
data  input  DATA_W  parallel word, sampled on accept
ParityMode  input  2  sampled on accept: 0 none, 1 even, 2 odd, 3 treated as none
Load  input  1  load request (valid)
LoadReady  output  1  block can accept a word this cycle
serialOutput  output  1  registered serial bit
serialValid  output  1  serialOutput carries a frame bit this cycle
Busy  output  1  a frame is in progress
Done  output  1  one-cycle pulse concurrent with the last bit of a frame
BitCount  output  CNT_W  index of the bit on serialOutput (0 = first bit)

Behaviour:
- One clock, Clock. Reset is synchronous and active-high.
- While Reset=1, on each edge: serialOutput=0, serialValid=0, Busy=0, Done=0, BitCount=0, state=IDLE. LoadReady=0 while Reset=1, and LoadReady=1 in the first cycle after Reset is released.
- A Load seen while Reset=1 is ignored.
- Reset asserted mid-frame aborts the frame. No Done pulse is produced and no parity bit is sent.
- Accept: an edge where Load=1 and LoadReady=1. At that edge the block captures data and ParityMode.
- Frame length FL = DATA_W+1 if the captured mode is even or odd, otherwise DATA_W.
- States:
  - IDLE: not transmitting.
  - DATA: transmitting data bits.
  - PAR: transmitting the parity bit.
- Latency: the first bit appears on serialOutput in the cycle immediately after the accept edge, with serialValid=1, Busy=1 and BitCount=0.
- Each following edge advances one bit and increments BitCount.
- Data bit order:
  - MSB_FIRST=0: data[0], data[1], ..., data[DATA_W-1].
  - MSB_FIRST=1: data[DATA_W-1] down to data[0].
- Parity bit is sent after the last data bit, state PAR, BitCount=DATA_W.
  - Even mode: parity bit = XOR of all data bits, so the total count of ones in the frame is even.
  - Odd mode: parity bit = the inverse of that XOR.
  - Parity is accumulated as bits shift out or precomputed at accept; both give identical output.
- Last-bit cycle (BitCount = FL-1):
  - Done=1 and LoadReady=1.
  - If a word is accepted at the closing edge, the next cycle shows the new frame's bit 0. There is no gap, Busy stays 1 and BitCount returns to 0.
  - Otherwise the next cycle is IDLE: serialOutput=0, serialValid=0, Busy=0, BitCount=0.
- LoadReady = (state==IDLE) OR (last-bit cycle), gated by Reset. It is combinational from registered state and has no dependence on Load.
- Load while LoadReady=0 (mid-frame) is ignored. data and ParityMode may change freely mid-frame without affecting the frame in progress.
- DATA_W=1 with mode none: every frame is one bit long and Done=1 on every frame bit.
- All arithmetic is unsigned. BitCount never exceeds DATA_W.

Test Plan:
- Basic even parity: DATA_W=7, MSB_FIRST=0, data=7'h59, mode 1, single Load pulse. Required serial sequence 1,0,0,1,1,0,1 then parity 0. BitCount runs 0..7. Done only at BitCount=7. Returns to IDLE on the next cycle.
- Odd parity and MSB-first: same data with mode 2, built with MSB_FIRST=1. Required sequence 1,0,1,1,0,0,1 then parity 1.
- No parity: mode 0, data=7'h7F, Load held high continuously. Required: 7 ones per frame, Done at BitCount=6, and the next frame starts in the following cycle with serialValid never dropping. LoadReady is 1 only at BitCount=6.
- Ignored load: assert Load with data=7'h00 at BitCount=3 of a 7'h59 even frame. Required: the frame in progress is unaffected (still sends 1,0,0,1,1,0,1,0) and no second frame is queued.
- Reset mid-frame: assert Reset for one cycle at BitCount=4. Required: the next cycle shows all outputs 0 and no Done. LoadReady=1 one cycle after release. A new 7'h59 frame then transmits correctly.
- Width variant: DATA_W=8, data=8'hA5, mode 1 (even). Required sequence 1,0,1,0,0,1,0,1 then parity 0. BitCount reaches 8.
